// File: rtl/stack_access_sequencer.sv
// rtl/stack_access_sequencer.sv - operand stack sequencer driving a 1-cycle-latency single-port stack RAM.
// Optional top-of-stack register cache enabled by defining STACK_TOS_CACHE_EN.
module stack_access_sequencer #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16,
  localparam int SPW = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [WIDTH-1:0] cmd_data,
  output logic             rsp_valid,
  output logic [WIDTH-1:0] rsp_data,
  output logic             rsp_err,
  output logic             ram_en,
  output logic             ram_we,
  output logic [SPW-2:0]   ram_addr,
  output logic [WIDTH-1:0] ram_wdata,
  input  logic [WIDTH-1:0] ram_rdata,
  output logic [SPW-1:0]   count,
  output logic             full,
  output logic             empty,
  output logic             err_ovf,
  output logic             err_udf
);

  localparam logic [1:0] OP_PUSH  = 2'b00;
  localparam logic [1:0] OP_POP   = 2'b01;
  localparam logic [1:0] OP_TOS   = 2'b10;
  localparam logic [1:0] OP_CLEAR = 2'b11;

  typedef enum logic [1:0] {
    IDLE, EXEC, RDATA
`ifdef STACK_TOS_CACHE_EN
    , REFILL
`endif
  } state_t;

  state_t           state_q, state_d;
  logic [1:0]       op_q, op_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic [SPW-1:0]   count_q, count_d;
  logic             err_ovf_q, err_ovf_d;
  logic             err_udf_q, err_udf_d;
  logic [SPW-1:0]   count_m1;
  logic             full_w, empty_w;
`ifdef STACK_TOS_CACHE_EN
  logic [WIDTH-1:0] tos_q, tos_d;
  logic [SPW-1:0]   count_m2;
  assign count_m2 = count_q - 2'd2;
`endif

  assign count_m1  = count_q - 1'b1;
  assign full_w    = (count_q == SPW'(DEPTH));
  assign empty_w   = (count_q == '0);
  assign cmd_ready = (state_q == IDLE);
  assign count     = count_q;
  assign full      = full_w;
  assign empty     = empty_w;
  assign err_ovf   = err_ovf_q;
  assign err_udf   = err_udf_q;

  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    data_d    = data_q;
    count_d   = count_q;
    err_ovf_d = err_ovf_q;
    err_udf_d = err_udf_q;
`ifdef STACK_TOS_CACHE_EN
    tos_d     = tos_q;
`endif
    rsp_valid = 1'b0;
    rsp_data  = '0;
    rsp_err   = 1'b0;
    ram_en    = 1'b0;
    ram_we    = 1'b0;
    ram_addr  = '0;
    ram_wdata = '0;
    case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          op_d    = cmd_op;
          data_d  = cmd_data;
          state_d = EXEC;
        end
      end
      EXEC: begin
        state_d = IDLE;
        case (op_q)
          OP_PUSH: begin
            rsp_valid = 1'b1;
            if (full_w) begin
              rsp_err   = 1'b1;
              err_ovf_d = 1'b1;
            end else begin
              count_d = count_q + 1'b1;
`ifdef STACK_TOS_CACHE_EN
              // The cached top spills into RAM only when something is already on the stack.
              ram_en    = !empty_w;
              ram_we    = !empty_w;
              ram_addr  = count_m1[SPW-2:0];
              ram_wdata = tos_q;
              tos_d     = data_q;
`else
              ram_en    = 1'b1;
              ram_we    = 1'b1;
              ram_addr  = count_q[SPW-2:0];
              ram_wdata = data_q;
`endif
            end
          end
          OP_POP, OP_TOS: begin
            if (empty_w) begin
              rsp_valid = 1'b1;
              rsp_err   = 1'b1;
              err_udf_d = 1'b1;
            end else begin
`ifdef STACK_TOS_CACHE_EN
              rsp_valid = 1'b1;
              rsp_data  = tos_q;
              if (op_q == OP_POP) begin
                count_d = count_m1;
                if (count_q >= SPW'(2)) begin
                  ram_en   = 1'b1;
                  ram_addr = count_m2[SPW-2:0];
                  state_d  = REFILL;
                end
              end
`else
              ram_en   = 1'b1;
              ram_addr = count_m1[SPW-2:0];
              state_d  = RDATA;
`endif
            end
          end
          default: begin
            rsp_valid = 1'b1;
            count_d   = '0;
            err_ovf_d = 1'b0;
            err_udf_d = 1'b0;
          end
        endcase
      end
      RDATA: begin
        rsp_valid = 1'b1;
        rsp_data  = ram_rdata;
        if (op_q == OP_POP) count_d = count_m1;
        state_d = IDLE;
      end
`ifdef STACK_TOS_CACHE_EN
      REFILL: begin
        tos_d   = ram_rdata;
        state_d = IDLE;
      end
`endif
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      op_q      <= OP_PUSH;
      data_q    <= '0;
      count_q   <= '0;
      err_ovf_q <= 1'b0;
      err_udf_q <= 1'b0;
`ifdef STACK_TOS_CACHE_EN
      tos_q     <= '0;
`endif
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      data_q    <= data_d;
      count_q   <= count_d;
      err_ovf_q <= err_ovf_d;
      err_udf_q <= err_udf_d;
`ifdef STACK_TOS_CACHE_EN
      tos_q     <= tos_d;
`endif
    end
  end

endmodule

// File: tb/tb_stack_access_sequencer.sv
// tb/tb_stack_access_sequencer.sv - directed self-checking bench for stack_access_sequencer.
module tb_stack_access_sequencer;

  localparam int WIDTH = 8;
  localparam int DEPTH = 16;
  localparam int SPW   = $clog2(DEPTH + 1);
`ifdef STACK_TOS_CACHE_EN
  localparam int RD_LAT = 1;
`else
  localparam int RD_LAT = 2;
`endif

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             cmd_valid = 1'b0;
  logic             cmd_ready;
  logic [1:0]       cmd_op = 2'b00;
  logic [WIDTH-1:0] cmd_data = '0;
  logic             rsp_valid;
  logic [WIDTH-1:0] rsp_data;
  logic             rsp_err;
  logic             ram_en;
  logic             ram_we;
  logic [SPW-2:0]   ram_addr;
  logic [WIDTH-1:0] ram_wdata;
  logic [WIDTH-1:0] ram_rdata = '0;
  logic [SPW-1:0]   count;
  logic             full;
  logic             empty;
  logic             err_ovf;
  logic             err_udf;

  logic [WIDTH-1:0] mem [DEPTH];

  int checks = 0;
  int errors = 0;

  stack_access_sequencer #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_data(cmd_data),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_err(rsp_err),
    .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
    .ram_rdata(ram_rdata),
    .count(count), .full(full), .empty(empty), .err_ovf(err_ovf), .err_udf(err_udf)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (ram_en) begin
      if (ram_we) mem[ram_addr] <= ram_wdata;
      else        ram_rdata <= mem[ram_addr];
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Issue one command and collect its response; sampling happens on falling edges.
  task automatic do_cmd(input logic [1:0] op, input logic [WIDTH-1:0] d,
                        output logic [WIDTH-1:0] rd, output logic er,
                        output int lat, output logic ram_seen);
    int guard;
    logic got;
    guard = 0;
    @(negedge clk);
    while (!cmd_ready && guard < 10) begin
      @(negedge clk);
      guard++;
    end
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_data  = d;
    @(negedge clk);
    cmd_valid = 1'b0;
    got = 1'b0;
    ram_seen = 1'b0;
    rd = '0;
    er = 1'b0;
    lat = 0;
    for (int i = 1; i <= 8 && !got; i++) begin
      if (ram_en) ram_seen = 1'b1;
      if (rsp_valid) begin
        got = 1'b1;
        lat = i;
        rd  = rsp_data;
        er  = rsp_err;
      end else begin
        @(negedge clk);
      end
    end
    if (!got) check("rsp_timeout", 32'd0, 32'd1);
  endtask

  logic [WIDTH-1:0] rd;
  logic             er;
  int               lat;
  logic             rs;
  int               accepts;
  logic [WIDTH-1:0] exp_pop [4];

  initial begin
    exp_pop[0] = 8'h33; exp_pop[1] = 8'h33; exp_pop[2] = 8'h22; exp_pop[3] = 8'h11;
    for (int i = 0; i < DEPTH; i++) mem[i] = 8'hEE;
    repeat (2) @(negedge clk);
    check("rst_ready", 32'(cmd_ready), 32'd1);
    check("rst_count", 32'(count), 32'd0);
    check("rst_empty", 32'(empty), 32'd1);
    check("rst_rsp", {30'd0, rsp_valid, ram_en}, 32'd0);
    check("rst_errs", {30'd0, err_ovf, err_udf}, 32'd0);
    rst = 1'b0;

    do_cmd(2'b00, 8'h11, rd, er, lat, rs);
    check("push1_err", 32'(er), 32'd0);
    check("push1_lat", 32'(lat), 32'd1);
    do_cmd(2'b00, 8'h22, rd, er, lat, rs);
    check("push2_data", 32'(rd), 32'd0);
    do_cmd(2'b00, 8'h33, rd, er, lat, rs);
    check("push3_err", 32'(er), 32'd0);
    @(negedge clk);
    check("push_count", 32'(count), 32'd3);
`ifndef STACK_TOS_CACHE_EN
    check("ram_012", {8'd0, mem[0], mem[1], mem[2]}, 32'h00112233);
`endif

    for (int i = 0; i < 4; i++) begin
      do_cmd((i == 0) ? 2'b10 : 2'b01, 8'h00, rd, er, lat, rs);
      check("pop_data", 32'(rd), 32'(exp_pop[i]));
      check("pop_lat", 32'(lat), 32'(RD_LAT));
    end
    @(negedge clk);
    @(negedge clk);
    check("pop_count", 32'(count), 32'd0);
    check("pop_empty", 32'(empty), 32'd1);

    do_cmd(2'b01, 8'h00, rd, er, lat, rs);
    check("udf_err", 32'(er), 32'd1);
    check("udf_noram", 32'(rs), 32'd0);
    @(negedge clk);
    check("udf_flag", 32'(err_udf), 32'd1);
    do_cmd(2'b11, 8'h00, rd, er, lat, rs);
    @(negedge clk);
    check("clr_udf", 32'(err_udf), 32'd0);
    check("clr_err", 32'(er), 32'd0);

    for (int i = 0; i < DEPTH; i++) do_cmd(2'b00, WIDTH'(i + 8'h40), rd, er, lat, rs);
    @(negedge clk);
    check("full", 32'(full), 32'd1);
    do_cmd(2'b00, 8'h99, rd, er, lat, rs);
    check("ovf_err", 32'(er), 32'd1);
    check("ovf_noram", 32'(rs), 32'd0);
    @(negedge clk);
    check("ovf_flag", 32'(err_ovf), 32'd1);
    check("ovf_count", 32'(count), 32'd16);
`ifndef STACK_TOS_CACHE_EN
    check("ovf_ram15", 32'(mem[15]), 32'h4F);
`endif

    do_cmd(2'b11, 8'h00, rd, er, lat, rs);
    @(negedge clk);
    check("clr_ovf", 32'(err_ovf), 32'd0);

    accepts = 0;
    cmd_valid = 1'b1;
    cmd_op    = 2'b00;
    cmd_data  = 8'hA5;
    for (int i = 0; i < 8; i++) begin
      if (cmd_ready) accepts++;
      check("hold_ready", 32'(cmd_ready), (i % 2 == 0) ? 32'd1 : 32'd0);
      @(negedge clk);
    end
    cmd_valid = 1'b0;
    @(negedge clk);
    check("hold_accepts", 32'(accepts), 32'd4);
    check("hold_count", 32'(count), 32'd4);

    do_cmd(2'b11, 8'h00, rd, er, lat, rs);
    do_cmd(2'b00, 8'h77, rd, er, lat, rs);
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_op    = 2'b01;
    @(negedge clk);
    cmd_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("rst_mid_rsp", 32'(rsp_valid), 32'd0);
    check("rst_mid_count", 32'(count), 32'd0);
    check("rst_mid_ready", 32'(cmd_ready), 32'd1);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
